// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, decoder control inputs and fetch status outputs.
// The master modport is the fetch unit; the slave modport is the memory/decoder side.
interface fetch_unit_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic              exec_en;
    logic [2:0]        smuxPC;
    logic              halt;
    logic              ctl_reset;
    logic              alu_zero;
    logic [ADDR_W-1:0] reg_target;
    logic              ready;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic [31:0]       instr_count;

    modport master (
        output imem_addr, instr, opcode, exec_en, pc, halted, instr_count,
        input  imem_data, smuxPC, halt, ctl_reset, alu_zero, reg_target, ready
    );

    modport slave (
        input  imem_addr, instr, opcode, exec_en, pc, halted, instr_count,
        output imem_data, smuxPC, halt, ctl_reset, alu_zero, reg_target, ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: FETCH -> LOAD -> EXEC, with IN-stall and HLT states.
// Define FETCH_INSTR_COUNT_EN to build the retired-instruction counter.
module fetch_unit #(
    parameter int ADDR_W = 10,
    parameter int OFF_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    typedef enum logic [2:0] {
        FETCH,
        LOAD,
        EXEC,
        WAIT_IN,
        HALTED
    } state_t;

    localparam logic [5:0] OP_IN = 6'b010110;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       instr, instr_n;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] next_pc;

    assign opcode = instr[31:26];
    assign seq_pc = pc + ADDR_W'(1);
    // Sign-extend or truncate the branch offset to the PC width.
    assign offset    = ADDR_W'(signed'(instr[OFF_W-1:0]));
    assign branch_pc = seq_pc + offset;

    always_comb begin
        next_pc = seq_pc;
        case (bus.smuxPC)
            3'b001:  next_pc = bus.alu_zero  ? branch_pc : seq_pc;
            3'b010:  next_pc = !bus.alu_zero ? branch_pc : seq_pc;
            3'b011:  next_pc = instr[ADDR_W-1:0];
            3'b100:  next_pc = bus.reg_target;
            default: next_pc = seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            pc        <= '0;
            instr     <= '0;
            imem_addr <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            instr <= instr_n;
            // Address is loaded on entry to FETCH so it equals pc throughout FETCH.
            if (state_n == FETCH) begin
                imem_addr <= pc_n;
            end
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instr;
        case (state)
            FETCH: state_n = LOAD;
            LOAD: begin
                instr_n = bus.imem_data;
                state_n = EXEC;
            end
            EXEC: begin
                if (bus.ctl_reset) begin
                    pc_n    = '0;
                    state_n = FETCH;
                end else if (bus.halt && opcode == OP_IN) begin
                    state_n = WAIT_IN;
                end else if (bus.halt) begin
                    state_n = HALTED;
                end else begin
                    pc_n    = next_pc;
                    state_n = FETCH;
                end
            end
            WAIT_IN: begin
                if (bus.ready) begin
                    state_n = EXEC;
                end
            end
            HALTED:  state_n = HALTED;
            default: state_n = FETCH;
        endcase
    end

    assign bus.imem_addr = imem_addr;
    assign bus.instr     = instr;
    assign bus.opcode    = opcode;
    assign bus.pc        = pc;
    assign bus.exec_en   = (state == EXEC);
    assign bus.halted    = (state == HALTED);

`ifdef FETCH_INSTR_COUNT_EN
    logic        retire;
    logic [31:0] count;

    // Retired: EXEC leaving by HLT or by a normal next-PC update.
    assign retire = (state == EXEC) && !bus.ctl_reset && !(bus.halt && opcode == OP_IN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (retire) begin
            count <= count + 32'd1;
        end
    end

    assign bus.instr_count = count;
`else
    assign bus.instr_count = '0;
`endif
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter stage that sits directly upstream of the opcode decoder. It holds the PC, reads the synchronous instruction memory and latches the instruction register. The decoder's `opcode` is taken from that register. The block consumes the decoder's `smuxPC`, `halt` and `reset` outputs to choose the next PC, stall on input-device waits and stop on HLT. One instruction takes 3 cycles: fetch, load, execute.

## Interface
- `ADDR_W`, default 10: PC and instruction-memory address width.
- `OFF_W`, default 16: width of the signed branch offset field `instr[OFF_W-1:0]`. Must satisfy `OFF_W` ≤ 26.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: reset, asynchronous, active-low.
- `imem_addr` out `ADDR_W`: instruction-memory address. The memory returns data one cycle later.
- `imem_data` in 32: instruction-memory read data.
- `instr` out 32: instruction register.
- `opcode` out 6: `instr[31:26]`, fed to the decoder.
- `exec_en` out 1: high only in EXEC. Downstream gates register, memory and display writes with it.
- `smuxPC` in 3: next-PC select from the decoder.
- `halt` in 1: halt request from the decoder.
- `ctl_reset` in 1: illegal-opcode reset request from the decoder.
- `alu_zero` in 1: ALU result-is-zero flag.
- `reg_target` in `ADDR_W`: jump-register target from the register file.
- `ready` in 1: input device has data.
- `pc` out `ADDR_W`: current PC.
- `halted` out 1: high in HALTED.
- `instr_count` out 32: count of retired instructions (see Configuration).

## Operation
- **States:** FETCH, LOAD, EXEC, WAIT_IN, HALTED.
- **FETCH:** drive `imem_addr = pc`; go to LOAD.
- **LOAD:** `instr <= imem_data`; go to EXEC.
- **EXEC:** `exec_en = 1`. Actions are evaluated in priority order:
  1. `ctl_reset = 1`: `pc <= 0`, go to FETCH. The instruction is not retired.
  2. `halt = 1` and `opcode == 6'b010110` (IN): go to WAIT_IN; `pc` held.
  3. `halt = 1` with any other opcode: go to HALTED; `pc` held; the instruction is retired.
  4. Otherwise: `pc <= next_pc`, go to FETCH; the instruction is retired.
- **next_pc** (all arithmetic modulo 2^`ADDR_W`, so results wrap):
  - `000`: `pc + 1`.
  - `001`: if `alu_zero` then `pc + 1 + sext(instr[OFF_W-1:0])`, else `pc + 1`. The offset is truncated to `ADDR_W`.
  - `010`: same as `001` with the condition inverted (`!alu_zero`).
  - `011`: `instr[ADDR_W-1:0]`.
  - `100`: `reg_target`.
  - `101`–`111`: `pc + 1`.
- **WAIT_IN:** `exec_en = 0`; `pc` and `instr` held. When `ready = 1` is sampled, go to EXEC. The decoder then sees `ready = 1`, drops `halt` and asserts the register write.
- **HALTED:** all state frozen; `halted = 1`. Only `reset` exits this state.

## Timing
- **Reset values:** `pc = 0`, `instr = 0`, `imem_addr = 0`, `exec_en = 0`, `halted = 0`, `instr_count = 0`, state = FETCH.
- **Reset assertion:** takes effect immediately from any state, including mid-WAIT_IN and HALTED.
- **Reset release:** FETCH is entered on the first rising edge after `reset` goes high.
- **`imem_addr`:** registered; equals `pc` in FETCH and holds its value in all other states.
- **Throughput:** one EXEC cycle per 3 clocks when there are no stalls.
- **Next-PC visibility:** the new `pc` is visible the cycle after EXEC.
- **Input-sampling window:**
  - `smuxPC`, `halt`, `ctl_reset`, `alu_zero` and `reg_target` are sampled only in EXEC.
  - `ready` is sampled only in WAIT_IN.
  - Values on these inputs in other states have no effect.
- **IN stall timing:** `ready` sampled high in WAIT_IN gives EXEC on the next cycle. Minimum IN latency is 5 cycles.

## Configuration
- **`FETCH_INSTR_COUNT_EN` defined:**
  - `instr_count` is a 32-bit register incremented on every retired instruction (EXEC exits via rules 3 and 4).
  - It is not incremented on `ctl_reset` or on entry to WAIT_IN.
  - It wraps from `0xFFFFFFFF` to 0.
- **`FETCH_INSTR_COUNT_EN` undefined:** `instr_count` is tied to 0 and no counter logic is built.

## Test plan
- **Reset and sequential fetch:** release reset; memory holds three `000001` instructions; `smuxPC = 000`. Expect `exec_en` high on cycles 3, 6 and 9, and `pc` = 1, 2, 3 after each.
- **Branches:** at `pc = 5`, `smuxPC = 001`, `alu_zero = 1`, offset `0xFFFE` → `pc = 4`. Same setup with `alu_zero = 0` → `pc = 6`. At `pc = 1023`, `smuxPC = 000` → `pc = 0` (wrap).
- **Jumps:** `smuxPC = 011` with `instr[9:0] = 0x155` → `pc = 0x155`. `smuxPC = 100` with `reg_target = 0x3FF` → `pc = 0x3FF`.
- **IN stall:** opcode IN with `halt = 1` in EXEC. Hold `ready = 0` for 10 cycles: `pc` and `instr` stable, `exec_en = 0`. Raise `ready` → one EXEC cycle follows, then `pc + 1`.
- **HLT, illegal opcode and reset:** opcode `010101` → `halted = 1`, `pc` frozen, `instr_count` stops. `ctl_reset = 1` in EXEC → `pc = 0`, count unchanged. `reset` low mid-WAIT_IN → all outputs at reset values immediately.
